// File: rtl/alu_pkg.sv
// Shared opcode/rollop encodings and FSM state type for the sequential ALU.
package alu_pkg;

    localparam int unsigned OP_W     = 4;
    localparam int unsigned ROLLOP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD  = 4'b1000;
    localparam logic [OP_W-1:0] OP_AND  = 4'b1001;
    localparam logic [OP_W-1:0] OP_OR   = 4'b1010;
    localparam logic [OP_W-1:0] OP_XOR  = 4'b1011;
    localparam logic [OP_W-1:0] OP_ROLL = 4'b1100;
    localparam logic [OP_W-1:0] OP_NOT  = 4'b1101;
    localparam logic [OP_W-1:0] OP_CS1  = 4'b1110;
    localparam logic [OP_W-1:0] OP_CS2  = 4'b1111;

    localparam logic [ROLLOP_W-1:0] RO_RBL = 3'b010;
    localparam logic [ROLLOP_W-1:0] RO_RBR = 3'b011;
    localparam logic [ROLLOP_W-1:0] RO_RNL = 3'b110;
    localparam logic [ROLLOP_W-1:0] RO_RNR = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic rollop_valid(input logic [ROLLOP_W-1:0] ro);
        return (ro == RO_RBL) || (ro == RO_RBR) || (ro == RO_RNL) || (ro == RO_RNR);
    endfunction

endpackage

// File: rtl/alu_rot_step.sv
// One-position rotator: bit roll through L, or nibble roll of W.
module alu_rot_step
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0]    w_i,
    input  logic                wl_i,
    input  logic [ROLLOP_W-1:0] rollop_i,
    output logic [WIDTH-1:0]    w_o,
    output logic                wl_o
);

    always_comb begin : rot
        w_o  = w_i;
        wl_o = wl_i;
        case (rollop_i)
            RO_RBL: begin
                w_o  = {w_i[WIDTH-2:0], wl_i};
                wl_o = w_i[WIDTH-1];
            end
            RO_RBR: begin
                w_o  = {wl_i, w_i[WIDTH-1:1]};
                wl_o = w_i[0];
            end
            RO_RNL: w_o = {w_i[WIDTH-5:0], w_i[WIDTH-1:WIDTH-4]};
            RO_RNR: w_o = {w_i[3:0], w_i[WIDTH-1:4]};
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: operand registers, single-cycle logic unit and a
// start/busy/done sequencer that rolls one position per clock.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    ibus,
    input  logic                w_a,
    input  logic                w_b,
    input  logic                start,
    input  logic [OP_W-1:0]     runit,
    input  logic [ROLLOP_W-1:0] rollop,
    input  logic [CNT_W-1:0]    count,
    input  logic                l_in,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    y,
    output logic                l_out,
    output logic                l_toggle
);

    localparam int unsigned SUM_W = WIDTH + 1;

    if (((WIDTH % 4) != 0) || (WIDTH < 8)) begin : g_width_check
        $error("alu_seq: WIDTH must be a multiple of 4 and at least 8");
    end

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]      w_q, w_d;
    logic                  wl_q, wl_d;
    logic [ROLLOP_W-1:0]   rollop_q, rollop_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [WIDTH-1:0]      y_q, y_d;
    logic                  l_out_q, l_out_d;
    logic                  l_toggle_q, l_toggle_d;

    logic [SUM_W-1:0]      sum_c;
    logic [WIDTH-1:0]      alu_y_c;
    logic                  alu_l_c;
    logic                  alu_t_c;
    logic                  roll_go_c;
    logic [WIDTH-1:0]      step_w_c;
    logic                  step_wl_c;

    alu_rot_step #(.WIDTH(WIDTH)) u_rot_step (
        .w_i      (w_q),
        .wl_i     (wl_q),
        .rollop_i (rollop_q),
        .w_o      (step_w_c),
        .wl_o     (step_wl_c)
    );

    // Single-cycle unit; rolls that finish immediately and NOPs pass A through.
    always_comb begin : alu_unit
        sum_c   = SUM_W'(a_q) + SUM_W'(b_q);
        alu_y_c = a_q;
        alu_l_c = l_in;
        alu_t_c = 1'b0;
        case (runit)
            OP_ADD: begin
                alu_y_c = sum_c[WIDTH-1:0];
                alu_t_c = sum_c[WIDTH];
                alu_l_c = l_in ^ sum_c[WIDTH];
            end
            OP_AND:  alu_y_c = a_q & b_q;
            OP_OR:   alu_y_c = a_q | b_q;
            OP_XOR:  alu_y_c = a_q ^ b_q;
            OP_NOT:  alu_y_c = ~a_q;
            default: ;
        endcase
        roll_go_c = (runit == OP_ROLL) && rollop_valid(rollop) && (count != '0);
    end

    always_comb begin : next_state
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        w_d        = w_q;
        wl_d       = wl_q;
        rollop_d   = rollop_q;
        cnt_d      = cnt_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        y_d        = y_q;
        l_out_d    = l_out_q;
        l_toggle_d = l_toggle_q;

        if (!w_a) a_d = ibus;
        if (!w_b) b_d = ibus;

        case (state_q)
            S_RUN: begin
                w_d   = step_w_c;
                wl_d  = step_wl_c;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    y_d        = step_w_c;
                    l_out_d    = step_wl_c;
                    l_toggle_d = 1'b0;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request.
                state_d = S_IDLE;
                if (start) begin
                    w_d      = a_q;
                    wl_d     = l_in;
                    rollop_d = rollop;
                    if (roll_go_c) begin
                        state_d = S_RUN;
                        cnt_d   = count;
                        busy_d  = 1'b1;
                    end else begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        y_d        = alu_y_c;
                        l_out_d    = alu_l_c;
                        l_toggle_d = alu_t_c;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin : regs
        if (reset) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            w_q        <= '0;
            wl_q       <= 1'b0;
            rollop_q   <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            y_q        <= '0;
            l_out_q    <= 1'b0;
            l_toggle_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            w_q        <= w_d;
            wl_q       <= wl_d;
            rollop_q   <= rollop_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            y_q        <= y_d;
            l_out_q    <= l_out_d;
            l_toggle_q <= l_toggle_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign y        = y_q;
    assign l_out    = l_out_q;
    assign l_toggle = l_toggle_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases plus random traffic against a
// behavioural model that computes each result in one go.
module tb_alu_seq;

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          reset;
    logic [W-1:0]  ibus;
    logic          w_a, w_b, start;
    logic [3:0]    runit;
    logic [2:0]    rollop;
    logic [CW-1:0] count;
    logic          l_in;
    logic          busy, done, l_out, l_toggle;
    logic [W-1:0]  y;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: what the outputs must be after the coming edge.
    logic          m_busy, m_done, m_l, m_t;
    logic [W-1:0]  m_y, a_m, b_m, p_y;
    logic          p_l;
    int            m_rem;

    alu_seq #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .ibus(ibus), .w_a(w_a), .w_b(w_b),
        .start(start), .runit(runit), .rollop(rollop), .count(count),
        .l_in(l_in), .busy(busy), .done(done), .y(y), .l_out(l_out),
        .l_toggle(l_toggle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // Whole-operation result from the arithmetic definition of each op.
    function automatic void compute(input logic [3:0] ru, input logic [2:0] ro,
                                    input logic [CW-1:0] cn, input logic li,
                                    input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] ry, output logic rl,
                                    output logic rt, output int n);
        logic [63:0] v;
        int k;
        ry = a; rl = li; rt = 1'b0; n = 0;
        case (ru)
            4'b1000: begin
                v  = 64'(a) + 64'(b);
                ry = v[15:0]; rt = v[16]; rl = li ^ v[16];
            end
            4'b1001: ry = a & b;
            4'b1010: ry = a | b;
            4'b1011: ry = a ^ b;
            4'b1101: ry = ~a;
            4'b1100: begin
                if (cn != 0 && (ro == 3'b010 || ro == 3'b011 || ro == 3'b110 || ro == 3'b101)) begin
                    n = int'(cn);
                    case (ro)
                        3'b010: begin
                            v = {47'b0, li, a}; k = n % 17;
                            v = ((v << k) | (v >> (17 - k))) & 64'h1FFFF;
                            ry = v[15:0]; rl = v[16];
                        end
                        3'b011: begin
                            v = {47'b0, a, li}; k = n % 17;
                            v = ((v >> k) | (v << (17 - k))) & 64'h1FFFF;
                            ry = v[16:1]; rl = v[0];
                        end
                        3'b110: begin
                            v = {48'b0, a}; k = (4 * n) % 16;
                            v = ((v << k) | (v >> (16 - k))) & 64'hFFFF;
                            ry = v[15:0];
                        end
                        default: begin
                            v = {48'b0, a}; k = (4 * n) % 16;
                            v = ((v >> k) | (v << (16 - k))) & 64'hFFFF;
                            ry = v[15:0];
                        end
                    endcase
                end
            end
            default: ;
        endcase
    endfunction

    task automatic model_edge();
        logic [W-1:0] ry;
        logic rl, rt;
        int n;
        if (reset) begin
            m_busy = 0; m_done = 0; m_y = '0; m_l = 0; m_t = 0;
            a_m = '0; b_m = '0; m_rem = 0;
        end else begin
            m_done = 0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_done = 1; m_y = p_y; m_l = p_l; m_t = 0;
                end
            end else if (start) begin
                compute(runit, rollop, count, l_in, a_m, b_m, ry, rl, rt, n);
                if (n == 0) begin
                    m_done = 1; m_y = ry; m_l = rl; m_t = rt;
                end else begin
                    m_rem = n; p_y = ry; p_l = rl;
                end
            end
            m_busy = (m_rem > 0);
            if (!w_a) a_m = ibus;
            if (!w_b) b_m = ibus;
        end
    endtask

    // Advance one cycle and compare every output against the model.
    task automatic step();
        model_edge();
        @(negedge clk);
        check("busy",     32'(busy),     32'(m_busy));
        check("done",     32'(done),     32'(m_done));
        check("y",        32'(y),        32'(m_y));
        check("l_out",    32'(l_out),    32'(m_l));
        check("l_toggle", 32'(l_toggle), 32'(m_t));
        reset = 0; w_a = 1; w_b = 1; start = 0;
    endtask

    task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
        w_a = 0; ibus = a; step();
        w_b = 0; ibus = b; step();
    endtask

    task automatic start_op(input logic [3:0] ru, input logic [2:0] ro,
                            input logic [CW-1:0] cn, input logic li);
        start = 1; runit = ru; rollop = ro; count = cn; l_in = li;
        step();
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (done) break;
            step();
        end
        check("done_wait", 32'(done), 32'd1);
    endtask

    initial begin
        reset = 1; ibus = '0; w_a = 1; w_b = 1; start = 0;
        runit = 4'b0000; rollop = 3'b000; count = '0; l_in = 0;
        m_rem = 0; p_y = '0; p_l = 0; a_m = '0; b_m = '0;
        step();
        reset = 1; step();

        // ADD with carry out
        load(16'hFFFF, 16'h0001);
        start_op(4'b1000, 3'b000, 4'd0, 1'b0);
        check("add_y", 32'(y), 32'h0000);
        check("add_toggle", 32'(l_toggle), 32'd1);
        check("add_lout", 32'(l_out), 32'd1);
        check("add_done", 32'(done), 32'd1);
        step();
        check("add_done_pulse", 32'(done), 32'd0);

        // RBL x1
        load(16'h8001, 16'h0000);
        start_op(4'b1100, 3'b010, 4'd1, 1'b0);
        check("rbl_busy", 32'(busy), 32'd1);
        step();
        check("rbl_done", 32'(done), 32'd1);
        check("rbl_y", 32'(y), 32'h0002);
        check("rbl_lout", 32'(l_out), 32'd1);
        step();

        // RBR x2
        load(16'h0001, 16'h0000);
        start_op(4'b1100, 3'b011, 4'd2, 1'b0);
        step();
        step();
        check("rbr_done", 32'(done), 32'd1);
        check("rbr_y", 32'(y), 32'h8000);
        check("rbr_lout", 32'(l_out), 32'd0);
        step();

        // RNL x3
        load(16'h1234, 16'h0000);
        start_op(4'b1100, 3'b110, 4'd3, 1'b1);
        step(); step(); step();
        check("rnl_done", 32'(done), 32'd1);
        check("rnl_y", 32'(y), 32'h4123);
        check("rnl_lout", 32'(l_out), 32'd1);
        step();

        // RNR count sweep
        for (int c = 0; c < 16; c++) begin
            load(16'($urandom), 16'($urandom));
            start_op(4'b1100, 3'b101, 4'(c), 1'($urandom));
            wait_done(20);
            step();
        end

        // Start ignored while running
        load(16'hABCD, 16'h1111);
        start_op(4'b1100, 3'b110, 4'd4, 1'b0);
        start_op(4'b1000, 3'b000, 4'd0, 1'b0);
        wait_done(10);
        check("ign_y", 32'(y), 32'hABCD);
        step();
        check("ign_no_second", 32'(done), 32'd0);
        step();
        check("ign_no_second2", 32'(done), 32'd0);

        // AND, then back-to-back OR started during DONE
        load(16'hF0F0, 16'h3C3C);
        start_op(4'b1001, 3'b000, 4'd0, 1'b0);
        check("and_y", 32'(y), 32'h3030);
        check("and_done", 32'(done), 32'd1);
        start_op(4'b1010, 3'b000, 4'd0, 1'b0);
        check("b2b_done", 32'(done), 32'd1);
        check("b2b_y", 32'(y), 32'hFCFC);
        step();

        // A write coinciding with start uses the old A
        load(16'h00FF, 16'h0F0F);
        w_a = 0; ibus = 16'hFFFF;
        start_op(4'b1011, 3'b000, 4'd0, 1'b0);
        check("olda_y", 32'(y), 32'h0FF0);
        start_op(4'b1101, 3'b000, 4'd0, 1'b0);
        check("newa_not", 32'(y), 32'h0000);
        step();

        // Reset aborts a running roll
        load(16'h1234, 16'h0000);
        start_op(4'b1000, 3'b000, 4'd0, 1'b1);
        step();
        start_op(4'b1100, 3'b110, 4'd8, 1'b1);
        step();
        reset = 1; step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_y", 32'(y), 32'h0000);
        check("rst_lout", 32'(l_out), 32'd0);
        for (int i = 0; i < 8; i++) step();
        load(16'h0005, 16'h0007);
        start_op(4'b1000, 3'b000, 4'd0, 1'b0);
        check("post_rst_y", 32'(y), 32'h000C);
        step();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            reset  = ($urandom_range(0, 63) == 0);
            w_a    = ($urandom_range(0, 3) != 0);
            w_b    = ($urandom_range(0, 3) != 0);
            start  = ($urandom_range(0, 2) == 0);
            ibus   = 16'($urandom);
            runit  = 4'($urandom);
            rollop = 3'($urandom);
            count  = 4'($urandom);
            l_in   = 1'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
